// File: rtl/divremsqrt_iter.sv
// divremsqrt_iter: iterative restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_RADIX4_EN to retire two quotient bits per cycle instead of one.
module divremsqrt_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            StallM,
  input  logic            DivStartE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  output logic            DivBusyE,
  output logic            DivDoneM,
  output logic [XLEN-1:0] DivResultM
);
`ifdef DIV_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT0 = CW'(XLEN / STEP - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_rem, r_quo, r_div, r_res;
  logic [CW-1:0] r_cnt;
  logic r_negq, r_negr, r_sel_rem;
  logic w_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_special, w_start;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_spec_res, w_rem_n, w_quo_n, w_q_fin, w_r_fin;
  logic [XLEN+STEP-1:0] w_shift, w_b1, w_mult;
  logic [STEP-1:0] w_qd;
  // Funct3E[2] is set for every divide op, so folding it in costs nothing
  assign w_signed   = Funct3E[2] & ~Funct3E[0];
  assign w_a_neg    = w_signed & ForwardedSrcAE[XLEN-1];
  assign w_b_neg    = w_signed & ForwardedSrcBE[XLEN-1];
  assign w_a_abs    = w_a_neg ? -ForwardedSrcAE : ForwardedSrcAE;
  assign w_b_abs    = w_b_neg ? -ForwardedSrcBE : ForwardedSrcBE;
  assign w_b_zero   = ForwardedSrcBE == '0;
  assign w_ovf      = w_signed && ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}} && ForwardedSrcBE == '1;
  assign w_special  = w_b_zero | w_ovf;
  assign w_spec_res = Funct3E[1] ? (w_b_zero ? ForwardedSrcAE : '0) : (w_b_zero ? '1 : ForwardedSrcAE);
  assign w_start    = r_state == IDLE && DivStartE && !FlushE;
  assign w_shift    = {r_rem, r_quo[XLEN-1 -: STEP]};
  assign w_b1       = {{STEP{1'b0}}, r_div};
`ifdef DIV_RADIX4_EN
  logic [XLEN+1:0] w_b2, w_b3;
  assign w_b2   = {1'b0, r_div, 1'b0};
  assign w_b3   = w_b1 + w_b2;
  assign w_qd   = (w_shift >= w_b3) ? 2'd3 : (w_shift >= w_b2) ? 2'd2 : (w_shift >= w_b1) ? 2'd1 : 2'd0;
  assign w_mult = w_qd == 2'd3 ? w_b3 : w_qd == 2'd2 ? w_b2 : w_qd == 2'd1 ? w_b1 : '0;
`else
  assign w_qd   = w_shift >= w_b1;
  assign w_mult = w_qd[0] ? w_b1 : '0;
`endif
  // the selected multiple leaves a remainder below |B|, so it fits XLEN bits
  assign w_rem_n = XLEN'(w_shift - w_mult);
  assign w_quo_n = {r_quo[XLEN-STEP-1:0], w_qd};
  assign w_q_fin = r_negq ? -w_quo_n : w_quo_n;
  assign w_r_fin = r_negr ? -w_rem_n : w_rem_n;
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_start ? (w_special ? DONE : BUSY) : IDLE) :
             r_state == BUSY ? (FlushE ? IDLE : r_cnt == '0 ? DONE : BUSY) :
             (FlushE || !StallM) ? IDLE : DONE;
  always_comb begin
    DivBusyE   = r_state == BUSY;
    DivDoneM   = r_state == DONE;
    DivResultM = r_res;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_negq    <= 1'b0;
      r_negr    <= 1'b0;
      r_sel_rem <= 1'b0;
    end else if (w_start) begin
      r_rem     <= '0;
      r_quo     <= w_a_abs;
      r_div     <= w_b_abs;
      r_cnt     <= CNT0;
      r_negq    <= w_a_neg ^ w_b_neg;
      r_negr    <= w_a_neg;
      r_sel_rem <= Funct3E[1];
      if (w_special) r_res <= w_spec_res;
    end else if (r_state == BUSY) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0 && !FlushE) r_res <= r_sel_rem ? w_r_fin : w_q_fin;
    end
endmodule

// File: tb/tb_divremsqrt_iter.sv
// tb_divremsqrt_iter: randomized and directed checks of divremsqrt_iter at XLEN=32
// against a plain-arithmetic division model.
module tb_divremsqrt_iter;
`ifdef DIV_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif
  logic clk = 1'b0, reset = 1'b0, FlushE = 1'b0, StallM = 1'b0, DivStartE = 1'b0;
  logic [31:0] ForwardedSrcAE = '0, ForwardedSrcBE = '0;
  logic [2:0] Funct3E = 3'b100;
  logic DivBusyE, DivDoneM;
  logic [31:0] DivResultM;
  int checks = 0, errors = 0;

  divremsqrt_iter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .StallM(StallM), .DivStartE(DivStartE),
    .ForwardedSrcAE(ForwardedSrcAE), .ForwardedSrcBE(ForwardedSrcBE), .Funct3E(Funct3E),
    .DivBusyE(DivBusyE), .DivDoneM(DivDoneM), .DivResultM(DivResultM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    longint sa, sb;
    sa = f[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = f[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (b == 32'h0) return f[1] ? a : 32'hFFFFFFFF;
    return f[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    return (b == 32'h0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : LAT;
  endfunction

  // called #1 after a rising edge with the DUT idle; returns with DivDoneM high (or timed out)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        output logic [31:0] res, output int cyc);
    ForwardedSrcAE = a;
    ForwardedSrcBE = b;
    Funct3E = f;
    DivStartE = 1'b1;
    @(posedge clk); #1;
    DivStartE = 1'b0;
    cyc = 1;
    while (!DivDoneM && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = DivResultM;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    DivStartE = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (DivBusyE !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", DivBusyE); end
    if (DivDoneM !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", DivDoneM); end
    if (DivResultM !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", DivResultM); end
    DivStartE = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_directed;
    logic [31:0] ta[6] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd9};
    logic [31:0] tb[6] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFE, 32'd3};
    logic [2:0]  tf[6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b110, 3'b101};
    logic [31:0] te[6] = '{32'h0000000E, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h1, 32'h3};
    logic [31:0] res;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tf[i], res, cyc);
      checks += 2;
      if (res !== te[i]) begin errors++; $display("FAIL directed_%0d result got %h want %h", i, res, te[i]); end
      if (cyc !== LAT) begin errors++; $display("FAIL directed_%0d latency got %0d want %0d", i, cyc, LAT); end
      step();
    end
  endtask

  task automatic test_special;
    logic [31:0] ta[4] = '{32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000};
    logic [31:0] tb[4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [2:0]  tf[4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] te[4] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0};
    logic [31:0] res;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tf[i], res, cyc);
      checks += 2;
      if (res !== te[i]) begin errors++; $display("FAIL special_%0d result got %h want %h", i, res, te[i]); end
      if (cyc !== 1) begin errors++; $display("FAIL special_%0d latency got %0d want 1", i, cyc); end
      step();
    end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int cyc;
    run_op(32'd100, 32'd7, 3'b101, res, cyc);
    step();
    ForwardedSrcAE = 32'd50;
    ForwardedSrcBE = 32'd5;
    DivStartE = 1'b1;
    step();
    DivStartE = 1'b0;
    repeat (9) step();
    checks++;
    if (DivBusyE !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b want 1", DivBusyE); end
    FlushE = 1'b1;
    step();
    FlushE = 1'b0;
    checks += 3;
    if (DivBusyE !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", DivBusyE); end
    if (DivDoneM !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", DivDoneM); end
    if (DivResultM !== 32'h0000000E) begin errors++; $display("FAIL flush_keep got %h want 0000000e", DivResultM); end
    FlushE = 1'b1;
    DivStartE = 1'b1;
    step();
    FlushE = 1'b0;
    DivStartE = 1'b0;
    checks++;
    if (DivBusyE !== 1'b0 || DivDoneM !== 1'b0) begin
      errors++; $display("FAIL flush_start busy/done got %b%b want 00", DivBusyE, DivDoneM);
    end
    run_op(32'd9, 32'd3, 3'b101, res, cyc);
    checks += 2;
    if (res !== 32'h3) begin errors++; $display("FAIL flush_after result got %h want 3", res); end
    if (cyc !== LAT) begin errors++; $display("FAIL flush_after latency got %0d want %0d", cyc, LAT); end
    step();
  endtask

  task automatic test_stall;
    logic [31:0] res;
    int cyc;
    StallM = 1'b1;
    run_op(32'hFFFFFFF9, 32'd2, 3'b100, res, cyc);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (DivDoneM !== 1'b1 || DivResultM !== 32'hFFFFFFFD) begin
        errors++; $display("FAIL stall_hold_%0d done=%b result=%h want 1 fffffffd", i, DivDoneM, DivResultM);
      end
    end
    StallM = 1'b0;
    step();
    checks++;
    if (DivDoneM !== 1'b0) begin errors++; $display("FAIL stall_release done got %b want 0", DivDoneM); end
    StallM = 1'b1;
    run_op(32'hCAFE0001, 32'h0, 3'b111, res, cyc);
    FlushE = 1'b1;
    step();
    FlushE = 1'b0;
    StallM = 1'b0;
    checks += 2;
    if (DivDoneM !== 1'b0) begin errors++; $display("FAIL flush_done_state done got %b want 0", DivDoneM); end
    if (DivResultM !== 32'hCAFE0001) begin errors++; $display("FAIL flush_done_keep got %h want cafe0001", DivResultM); end
  endtask

  task automatic test_capture;
    logic [31:0] res;
    int cyc;
    ForwardedSrcAE = 32'hFFFFFFF9;
    ForwardedSrcBE = 32'd2;
    Funct3E = 3'b100;
    DivStartE = 1'b1;
    step();
    DivStartE = 1'b0;
    ForwardedSrcAE = 32'd1000;
    ForwardedSrcBE = 32'd3;
    Funct3E = 3'b111;
    repeat (4) step();
    DivStartE = 1'b1;
    step();
    DivStartE = 1'b0;
    cyc = 6;
    while (!DivDoneM && cyc < 200) begin step(); cyc++; end
    checks += 2;
    if (DivResultM !== 32'hFFFFFFFD) begin errors++; $display("FAIL capture result got %h want fffffffd", DivResultM); end
    if (cyc !== LAT) begin errors++; $display("FAIL capture latency got %0d want %0d", cyc, LAT); end
    step();
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int cyc;
    run_op(32'd100, 32'd7, 3'b101, res, cyc);
    step();
    ForwardedSrcAE = 32'd77;
    ForwardedSrcBE = 32'd5;
    DivStartE = 1'b1;
    step();
    DivStartE = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    checks += 3;
    if (DivBusyE !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", DivBusyE); end
    if (DivDoneM !== 1'b0) begin errors++; $display("FAIL reset_mid_done got %b want 0", DivDoneM); end
    if (DivResultM !== 32'h0) begin errors++; $display("FAIL reset_mid_result got %h want 0", DivResultM); end
    reset = 1'b1;
    repeat (LAT + 2) step();
    checks++;
    if (DivDoneM !== 1'b0 || DivResultM !== 32'h0) begin
      errors++; $display("FAIL reset_mid_no_partial done=%b result=%h want 0 0", DivDoneM, DivResultM);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, res;
    logic [2:0] f;
    int cyc, sel;
    for (int i = 0; i < 40; i++) begin
      f = {1'b1, 2'($urandom_range(0, 3))};
      a = (i % 7 == 3) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 9);
      b = sel == 0 ? 32'h0 : sel == 1 ? 32'hFFFFFFFF : sel == 2 ? 32'($urandom_range(1, 15)) :
          sel == 3 ? (32'h80000000 | 32'($urandom_range(0, 255))) : $urandom;
      run_op(a, b, f, res, cyc);
      checks += 2;
      if (res !== model(a, b, f)) begin
        errors++; $display("FAIL random_%0d f=%b a=%h b=%h result got %h want %h", i, f, a, b, res, model(a, b, f));
      end
      if (cyc !== model_lat(a, b, f)) begin
        errors++; $display("FAIL random_%0d latency got %0d want %0d", i, cyc, model_lat(a, b, f));
      end
      step();
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int cyc;
    run_op(32'd1000, 32'd33, 3'b101, res, cyc);
    checks++;
    if (res !== 32'd30) begin errors++; $display("FAIL b2b_first got %h want %h", res, 32'd30); end
    step();
    checks++;
    if (DivDoneM !== 1'b0) begin errors++; $display("FAIL b2b_exit done got %b want 0", DivDoneM); end
    run_op(32'd1000, 32'd33, 3'b111, res, cyc);
    checks += 2;
    if (res !== 32'd10) begin errors++; $display("FAIL b2b_second got %h want %h", res, 32'd10); end
    if (cyc !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", cyc, LAT); end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_special();
    test_flush();
    test_stall();
    test_capture();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
